// File: rtl/scoreboard.sv
// Register scoreboard for the dual-issue pipeline: tracks in-flight producers per
// architectural register, tagged so only the youngest writer's writeback releases it.
module scoreboard #(
  parameter int unsigned TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             iss0_valid,
  input  logic             iss0_we,
  input  logic [4:0]       iss0_rd,
  input  logic             iss0_load,
  input  logic             iss1_valid,
  input  logic             iss1_we,
  input  logic [4:0]       iss1_rd,
  input  logic             iss1_load,
  output logic [TAG_W-1:0] iss0_tag,
  output logic [TAG_W-1:0] iss1_tag,
  input  logic             wb0_valid,
  input  logic [4:0]       wb0_rd,
  input  logic [TAG_W-1:0] wb0_tag,
  input  logic             wb1_valid,
  input  logic [4:0]       wb1_rd,
  input  logic [TAG_W-1:0] wb1_tag,
  output logic [31:0]      busy_vec,
  output logic [31:0]      load_pending_vec,
  output logic             sb_empty
);

  logic [31:0]      busy_q, busy_d;
  logic [31:0]      load_q, load_d;
  logic [TAG_W-1:0] tag_q [32];
  logic [TAG_W-1:0] tag_d [32];
  logic [TAG_W-1:0] next_tag_q, next_tag_d;

  logic eff0, eff1;

  assign eff0 = iss0_valid && iss0_we && (iss0_rd != 5'd0);
  assign eff1 = iss1_valid && iss1_we && (iss1_rd != 5'd0);

  assign iss0_tag = next_tag_q;
  assign iss1_tag = next_tag_q + TAG_W'(eff0);

  always_comb begin
    busy_d     = busy_q;
    load_d     = load_q;
    tag_d      = tag_q;
    next_tag_d = next_tag_q;

    if (flush) begin
      busy_d = '0;
      load_d = '0;
    end else begin
      next_tag_d = next_tag_q + TAG_W'(eff0) + TAG_W'(eff1);
      for (int unsigned i = 1; i < 32; i++) begin
        // Issue outranks writeback; slot1 is younger so it outranks slot0.
        if (eff1 && iss1_rd == 5'(i)) begin
          busy_d[i] = 1'b1;
          load_d[i] = iss1_load;
          tag_d[i]  = iss1_tag;
        end else if (eff0 && iss0_rd == 5'(i)) begin
          busy_d[i] = 1'b1;
          load_d[i] = iss0_load;
          tag_d[i]  = iss0_tag;
        end else if (busy_q[i] &&
                     ((wb0_valid && wb0_rd == 5'(i) && wb0_tag == tag_q[i]) ||
                      (wb1_valid && wb1_rd == 5'(i) && wb1_tag == tag_q[i]))) begin
          busy_d[i] = 1'b0;
          load_d[i] = 1'b0;
        end
      end
    end
    busy_d[0] = 1'b0;
    load_d[0] = 1'b0;
    tag_d[0]  = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      load_q     <= '0;
      next_tag_q <= '0;
      for (int unsigned i = 0; i < 32; i++) tag_q[i] <= '0;
    end else begin
      busy_q     <= busy_d;
      load_q     <= load_d;
      next_tag_q <= next_tag_d;
      for (int unsigned i = 0; i < 32; i++) tag_q[i] <= tag_d[i];
    end
  end

  assign busy_vec         = busy_q;
  assign load_pending_vec = load_q;
  assign sb_empty         = ~|busy_q;

endmodule

// File: tb/tb_scoreboard.sv
// Self-checking bench for scoreboard: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural register model.
module tb_scoreboard;
  localparam int TAG_W = 3;
  localparam int NTAG  = 1 << TAG_W;

  logic clk = 1'b0;
  logic rst, flush;
  logic iss0_valid, iss0_we, iss0_load, iss1_valid, iss1_we, iss1_load;
  logic [4:0] iss0_rd, iss1_rd, wb0_rd, wb1_rd;
  logic [TAG_W-1:0] iss0_tag, iss1_tag, wb0_tag, wb1_tag;
  logic wb0_valid, wb1_valid;
  logic [31:0] busy_vec, load_pending_vec;
  logic sb_empty;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  // Behavioural model: one record per architectural register plus the tag counter.
  bit m_busy [32];
  bit m_load [32];
  int m_tag  [32];
  int m_next;

  always #5 clk = ~clk;

  scoreboard #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .iss0_valid(iss0_valid), .iss0_we(iss0_we), .iss0_rd(iss0_rd), .iss0_load(iss0_load),
    .iss1_valid(iss1_valid), .iss1_we(iss1_we), .iss1_rd(iss1_rd), .iss1_load(iss1_load),
    .iss0_tag(iss0_tag), .iss1_tag(iss1_tag),
    .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb0_tag(wb0_tag),
    .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_tag(wb1_tag),
    .busy_vec(busy_vec), .load_pending_vec(load_pending_vec), .sb_empty(sb_empty)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_eff(input logic v, input logic we, input logic [4:0] rd);
    return v && we && rd != 5'd0;
  endfunction

  function automatic logic [31:0] m_busy_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic logic [31:0] m_load_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = m_load[i];
    return v;
  endfunction

  // Model update: writebacks retire against the old state, then issues land in
  // program order (slot0 then slot1), so later writers overwrite earlier ones.
  always @(posedge clk) begin
    int t0, t1;
    bit e0, e1;
    e0 = m_eff(iss0_valid, iss0_we, iss0_rd);
    e1 = m_eff(iss1_valid, iss1_we, iss1_rd);
    t0 = m_next;
    t1 = (m_next + (e0 ? 1 : 0)) % NTAG;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m_busy[i] = 0; m_load[i] = 0; m_tag[i] = 0; end
      m_next = 0;
    end else if (flush) begin
      for (int i = 0; i < 32; i++) begin m_busy[i] = 0; m_load[i] = 0; end
    end else begin
      if (wb0_valid && wb0_rd != 0 && m_busy[wb0_rd] && m_tag[wb0_rd] == int'(wb0_tag)) begin
        m_busy[wb0_rd] = 0; m_load[wb0_rd] = 0;
      end
      if (wb1_valid && wb1_rd != 0 && m_busy[wb1_rd] && m_tag[wb1_rd] == int'(wb1_tag)) begin
        m_busy[wb1_rd] = 0; m_load[wb1_rd] = 0;
      end
      if (e0) begin m_busy[iss0_rd] = 1; m_load[iss0_rd] = iss0_load; m_tag[iss0_rd] = t0; end
      if (e1) begin m_busy[iss1_rd] = 1; m_load[iss1_rd] = iss1_load; m_tag[iss1_rd] = t1; end
      m_next = (m_next + (e0 ? 1 : 0) + (e1 ? 1 : 0)) % NTAG;
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("busy_vec", busy_vec, m_busy_vec());
      chk("load_pending_vec", load_pending_vec, m_load_vec());
      chk("sb_empty", {31'b0, sb_empty}, {31'b0, m_busy_vec() == 32'd0});
      chk("iss0_tag", {29'b0, iss0_tag}, m_next);
      chk("iss1_tag", {29'b0, iss1_tag},
          (m_next + (m_eff(iss0_valid, iss0_we, iss0_rd) ? 1 : 0)) % NTAG);
    end
  end

  task automatic idle();
    rst = 0; flush = 0;
    iss0_valid = 0; iss0_we = 0; iss0_rd = 0; iss0_load = 0;
    iss1_valid = 0; iss1_we = 0; iss1_rd = 0; iss1_load = 0;
    wb0_valid = 0; wb0_rd = 0; wb0_tag = 0;
    wb1_valid = 0; wb1_rd = 0; wb1_tag = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set0(input logic [4:0] rd, input logic ld);
    iss0_valid = 1; iss0_we = 1; iss0_rd = rd; iss0_load = ld;
  endtask

  task automatic set1(input logic [4:0] rd, input logic ld);
    iss1_valid = 1; iss1_we = 1; iss1_rd = rd; iss1_load = ld;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); idle();
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    armed = 1'b1;
    idle(); #1;
    chk("reset_busy", busy_vec, 32'h0);
    chk("reset_load", load_pending_vec, 32'h0);
    chk("reset_empty", {31'b0, sb_empty}, 32'h1);
    chk("reset_tag0", {29'b0, iss0_tag}, 32'h0);
    chk("reset_tag1", {29'b0, iss1_tag}, 32'h0);

    // Basic issue/writeback
    set0(5'd5, 0); #1;
    chk("basic_tag", {29'b0, iss0_tag}, 32'h0);
    tick(); idle();
    chk("basic_busy5", {31'b0, busy_vec[5]}, 32'h1);
    chk("basic_load5", {31'b0, load_pending_vec[5]}, 32'h0);
    wb0_valid = 1; wb0_rd = 5'd5; wb0_tag = 3'd0;
    tick(); idle();
    chk("basic_clear", busy_vec, 32'h0);
    chk("basic_empty", {31'b0, sb_empty}, 32'h1);

    // WAW ordering
    do_reset();
    set0(5'd7, 1); tick(); idle();
    chk("waw_load7", load_pending_vec, 32'h80);
    set0(5'd7, 0); #1;
    chk("waw_tag1", {29'b0, iss0_tag}, 32'h1);
    tick(); idle();
    wb0_valid = 1; wb0_rd = 5'd7; wb0_tag = 3'd0; tick(); idle();
    chk("waw_stale_busy", busy_vec, 32'h80);
    chk("waw_stale_load", load_pending_vec, 32'h0);
    wb1_valid = 1; wb1_rd = 5'd7; wb1_tag = 3'd1; tick(); idle();
    chk("waw_clear", busy_vec, 32'h0);

    // Dual issue and tag advance
    do_reset();
    set0(5'd3, 0); set1(5'd4, 1); #1;
    chk("dual_tag0", {29'b0, iss0_tag}, 32'h0);
    chk("dual_tag1", {29'b0, iss1_tag}, 32'h1);
    tick(); idle(); #1;
    chk("dual_next", {29'b0, iss0_tag}, 32'h2);
    chk("dual_busy", busy_vec, 32'h18);
    chk("dual_load", load_pending_vec, 32'h10);
    iss0_valid = 1; iss0_we = 0; iss0_rd = 5'd6; set1(5'd4, 0); #1;
    chk("nowrite_tag1", {29'b0, iss1_tag}, 32'h2);
    tick(); idle(); #1;
    chk("nowrite_next", {29'b0, iss0_tag}, 32'h3);
    set0(5'd0, 1); set1(5'd0, 1); tick(); idle(); #1;
    chk("x0_next", {29'b0, iss0_tag}, 32'h3);
    chk("x0_busy", busy_vec, 32'h18);
    chk("model_next", m_next, 32'h3);

    // Simultaneous set and clear on x9
    do_reset();
    set0(5'd1, 0); set1(5'd2, 0); tick(); idle();
    set0(5'd9, 0); #1;
    chk("x9_tag2", {29'b0, iss0_tag}, 32'h2);
    tick(); idle();
    wb1_valid = 1; wb1_rd = 5'd9; wb1_tag = 3'd2; set0(5'd9, 1); #1;
    chk("x9_tag3", {29'b0, iss0_tag}, 32'h3);
    tick(); idle();
    chk("x9_stays", busy_vec, 32'h206);
    wb0_valid = 1; wb0_rd = 5'd9; wb0_tag = 3'd2;
    wb1_valid = 1; wb1_rd = 5'd1; wb1_tag = 3'd0; tick(); idle();
    chk("x9_stale", busy_vec, 32'h204);
    wb0_valid = 1; wb0_rd = 5'd9; wb0_tag = 3'd3;
    wb1_valid = 1; wb1_rd = 5'd9; wb1_tag = 3'd6; tick(); idle();
    chk("x9_clear", busy_vec, 32'h4);

    // Wrap-around
    do_reset();
    for (int k = 0; k < 10; k++) begin
      set0(5'(10 + k), 0); #1;
      chk("wrap_tag", {29'b0, iss0_tag}, k % 8);
      tick(); idle();
      wb0_valid = 1; wb0_rd = 5'(10 + k); wb0_tag = 3'(k % 8);
      tick(); idle();
      chk("wrap_clear", busy_vec, 32'h0);
    end

    // Flush and reset priority
    do_reset();
    set0(5'd1, 0); set1(5'd2, 1); tick(); idle();
    set0(5'd3, 1); set1(5'd4, 0); tick(); idle();
    chk("pre_flush_busy", busy_vec, 32'h1e);
    flush = 1; set0(5'd5, 1); wb0_valid = 1; wb0_rd = 5'd1; wb0_tag = 3'd0;
    tick(); idle(); #1;
    chk("flush_busy", busy_vec, 32'h0);
    chk("flush_load", load_pending_vec, 32'h0);
    chk("flush_next", {29'b0, iss0_tag}, 32'h4);
    set0(5'd6, 0); tick(); idle();
    rst = 1; flush = 1; set0(5'd7, 1); tick(); idle(); #1;
    chk("rst_busy", busy_vec, 32'h0);
    chk("rst_empty", {31'b0, sb_empty}, 32'h1);
    chk("rst_tag", {29'b0, iss0_tag}, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      idle();
      rst   = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 59) == 0);
      iss0_valid = $urandom_range(0, 1); iss0_we = ($urandom_range(0, 3) != 0);
      iss0_rd = 5'($urandom_range(0, 31)); iss0_load = $urandom_range(0, 1);
      iss1_valid = $urandom_range(0, 1); iss1_we = ($urandom_range(0, 3) != 0);
      iss1_rd = ($urandom_range(0, 7) == 0) ? iss0_rd : 5'($urandom_range(0, 31));
      iss1_load = $urandom_range(0, 1);
      wb0_valid = $urandom_range(0, 1); wb0_rd = 5'($urandom_range(0, 31));
      r = ($urandom_range(0, 3) != 0) ? m_tag[wb0_rd] : $urandom_range(0, NTAG - 1);
      wb0_tag = 3'(r);
      wb1_valid = $urandom_range(0, 1);
      wb1_rd = ($urandom_range(0, 5) == 0) ? wb0_rd : 5'($urandom_range(0, 31));
      r = ($urandom_range(0, 3) != 0) ? m_tag[wb1_rd] : $urandom_range(0, NTAG - 1);
      wb1_tag = 3'(r);
      tick();
    end
    idle();
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scoreboard.md
# scoreboard

Register scoreboard for the Stage-3 dual-issue pipeline. It tracks which architectural registers have an in-flight producer and which of those producers are loads, and drives `busy_vec` and `load_pending_vec` into the issue unit. Each issued writer receives a sequence tag. A writeback clears a register only when its tag matches the register's youngest writer, so older completions cannot release a register that a newer instruction still owns.

## Interface
- `TAG_W`, default 3: sequence-tag width. Must satisfy 2^TAG_W > maximum in-flight writers; the pipeline holds at most 4.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: discard all in-flight state (redirect or halt).
- `iss0_valid` in 1: slot0 issues this cycle.
- `iss0_we` in 1: slot0 writes a register.
- `iss0_rd` in 5: slot0 destination register.
- `iss0_load` in 1: slot0 is a load.
- `iss1_valid`, `iss1_we`, `iss1_rd`, `iss1_load`: same four signals for slot1, the younger slot.
- `iss0_tag` out TAG_W: tag assigned to slot0 this cycle.
- `iss1_tag` out TAG_W: tag assigned to slot1 this cycle.
- `wb0_valid` in 1, `wb0_rd` in 5, `wb0_tag` in TAG_W: writeback port 0.
- `wb1_valid` in 1, `wb1_rd` in 5, `wb1_tag` in TAG_W: writeback port 1.
- `busy_vec` out 32: register has a pending writer.
- `load_pending_vec` out 32: the pending writer is a load.
- `sb_empty` out 1: asserted when `busy_vec` == 0.

## Operation
- **Per-register state.** Each register has a `busy` bit, a `load` bit and a `tag[TAG_W]`.
- **x0.** Entry 0 is hard-wired to zero. Its bits never set, and `busy_vec[0]` and `load_pending_vec[0]` are always 0.
- **Effective set.** Slot n sets its entry when `issN_valid && issN_we && issN_rd != 0`.
- **Tag counter.** `next_tag` is a TAG_W-bit counter.
  - `iss0_tag = next_tag`.
  - `iss1_tag = next_tag + eff0`, where eff0 is 1 if slot0 has an effective set. The sum wraps modulo 2^TAG_W.
  - The counter advances by the number of effective sets (0, 1 or 2), modulo 2^TAG_W.
  - Non-writing issues consume no tag.
- **Issue.** On an effective set: `busy <= 1`, `load <= issN_load`, `tag <= issN_tag`.
  - This overwrites any older pending writer to the same register.
- **Writeback.** `wbN_valid && wbN_rd != 0 && busy[rd] && tag[rd] == wbN_tag` clears `busy` and `load` for that register.
  - A tag mismatch is a stale writeback and is ignored.
- **Priority within a cycle (highest first):**
  1. `rst`
  2. `flush`
  3. issue set
  4. writeback clear
- **Same-register cases:**
  - Issue and writeback hit the same register in one cycle: the issue wins, and the register stays busy with the new tag.
  - Both slots write the same rd: slot1 wins (`tag = iss1_tag`, `load = iss1_load`). The issue unit normally prevents this case.
  - Both writeback ports clear different registers in one cycle: both clears apply.
  - Both writeback ports name the same register: it clears if either port's tag matches.
- **Flush.** Clears every `busy` and `load` bit. `next_tag` is preserved.
  - Effective issues in the flush cycle are dropped.
  - Writebacks in the flush cycle have no effect.
- **Reset.** All `busy`, `load` and `tag` bits go to 0, and `next_tag` goes to 0.

## Timing
- **Output reset values:**
  - `busy_vec` = 0 and `load_pending_vec` = 0.
  - `sb_empty` = 1.
  - `iss0_tag` = 0 and `iss1_tag` = 0 (assuming `iss0_valid` is low).
- **Registered outputs.** `busy_vec`, `load_pending_vec` and `sb_empty` come from registered state only. There is no combinational path from the issue or writeback inputs to them.
- **Set latency.** An issue in cycle N is visible in `busy_vec` in cycle N+1.
- **Clear latency.** A writeback in cycle N clears the bit in cycle N+1. There is no same-cycle bypass; the issue unit sees the stale busy bit for exactly one cycle.
- **Tag outputs.** `iss0_tag` and `iss1_tag` are combinational from `next_tag` and `iss0_valid`/`iss0_we`/`iss0_rd`. They are valid in the issue cycle; the pipeline captures them into the EX registers.
- **Tag wrap.** After a 7 → 0 wrap, a tag is reused only once its previous holder has retired (guaranteed by the TAG_W constraint).
- **Reset mid-operation.** Reset takes effect at the next edge regardless of other inputs. All in-flight writebacks after reset are stale, because the busy bits are 0.

## Test plan
- **Basic issue and writeback.** Reset, then slot0 issues ADD x5 (tag 0). Expect `busy_vec[5]` = 1 at N+1 and `load_pending_vec[5]` = 0. `wb0` x5/tag 0 → bit clears next cycle and `sb_empty` = 1.
- **WAW ordering.** Slot0 issues LW x7 (tag 0), then ADD x7 (tag 1). Writeback x7/tag 0 → x7 stays busy and `load_pending_vec[7]` = 0. Writeback x7/tag 1 → x7 clears.
- **Dual issue and tag advance.** Both slots write (x3, x4): tags 0 and 1, next `next_tag` = 2. Slot0 non-writing with slot1 writing x4: `iss1_tag` = current `next_tag`, counter +1. Writes to x0 never set a bit and consume no tag.
- **Simultaneous set and clear.** x9 busy with tag 2. In one cycle, `wb1` x9/tag 2 and a new slot0 issue to x9 (tag 3) → x9 stays busy with tag 3.
- **Wrap-around.** Issue 10 single writes, retiring each. Tags run 0..7, 0, 1 and matching writebacks clear correctly across the wrap.
- **Flush and reset priority.** With 4 registers busy, assert flush together with a new issue → all vectors 0 next cycle and `next_tag` unchanged. Assert `rst` with flush and issue → all outputs at their reset values.
